// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, constants, state and F/D payload for the fetch front end.
package fetch_unit_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 32;
  localparam int CNT_W = 16;
  localparam logic [5:0] HALT_OP = 6'h3F;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  typedef logic [PC_W-1:0] pc_t;
  typedef logic [INSTR_W-1:0] instr_t;
  typedef enum logic {RUN, HALT} fetch_state_e;
  typedef struct packed {
    pc_t    pc;
    instr_t instr;
    logic   valid;
  } fd_t;
  localparam fd_t FD_EMPTY = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
endpackage

// File: rtl/fetch_unit_next_pc.sv
// fetch_next_pc: combinational next-PC, F/D flush/load and next-state selection.
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic         stall_i,
  input  logic         take_br_i,
  input  logic         jmp_i,
  input  pc_t          pc_branch_i,
  input  pc_t          pc_jmp_i,
  input  pc_t          pc_i,
  input  fetch_state_e state_i,
  input  logic         halt_det_i,
  output pc_t          next_pc_o,
  output logic         redirect_o,
  output logic         flush_o,
  output logic         load_o,
  output fetch_state_e next_state_o
);
  assign redirect_o = take_br_i | jmp_i;
  assign flush_o = redirect_o | (state_i == HALT);
  assign load_o = !flush_o && !stall_i;
  // taken branch is older than the jump, so its target wins
  assign next_pc_o = redirect_o ? (take_br_i ? pc_branch_i : pc_jmp_i)
                   : (load_o && !halt_det_i) ? pc_i + PC_W'(1) : pc_i;
  assign next_state_o = redirect_o ? RUN
                      : ((state_i == HALT) || (load_o && halt_det_i)) ? HALT : RUN;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, F/D boundary register, HALT state and saturating fetch counters.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch,
  input  logic               alu_zero,
  input  logic [PC_W-1:0]    pc_branch,
  input  logic               jmp,
  input  logic [PC_W-1:0]    pc_jmp,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [PC_W-1:0]    fd_pc,
  output logic [INSTR_W-1:0] fd_instr,
  output logic               fd_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   bubble_count
);
  fetch_state_e state_q, state_d;
  pc_t pc_q, pc_d;
  fd_t fd_q;
  logic [CNT_W-1:0] fetch_cnt_q, bubble_cnt_q;
  logic redirect, flush, load;
  fetch_next_pc u_next_pc (
    .stall_i     (stall),
    .take_br_i   (branch & alu_zero),
    .jmp_i       (jmp),
    .pc_branch_i (pc_branch),
    .pc_jmp_i    (pc_jmp),
    .pc_i        (pc_q),
    .state_i     (state_q),
    .halt_det_i  (imem_instr[31:26] == HALT_OP),
    .next_pc_o   (pc_d),
    .redirect_o  (redirect),
    .flush_o     (flush),
    .load_o      (load),
    .next_state_o(state_d)
  );
  // in HALT only the first flush (F/D still holds the HALT word) is a new bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q <= '0;
      fd_q <= FD_EMPTY;
      fetch_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      if (flush) fd_q <= FD_EMPTY;
      else if (load) fd_q <= '{pc: pc_q + PC_W'(1), instr: imem_instr, valid: 1'b1};
      if (load) fetch_cnt_q <= sat_inc(fetch_cnt_q);
      if (redirect || (state_q == HALT && fd_q.valid)) bubble_cnt_q <= sat_inc(bubble_cnt_q);
    end
  end
  assign imem_addr = pc_q;
  assign fd_pc = fd_q.pc;
  assign fd_instr = fd_q.instr;
  assign fd_valid = fd_q.valid;
  assign halted = (state_q == HALT);
  assign fetch_count = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a small reference model.
module tb_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, branch = 0, alu_zero = 0, jmp = 0;
  logic [7:0] pc_branch = 0, pc_jmp = 0, imem_addr, fd_pc;
  logic [31:0] imem_instr, fd_instr;
  logic fd_valid, halted;
  logic [15:0] fetch_count, bubble_count;
  logic [31:0] rom [256];
  int checks = 0, errors = 0;

  typedef struct {
    logic [7:0] addr, fpc;
    logic [31:0] fin;
    logic fv, hl;
    logic [15:0] fc, bc;
  } exp_t;
  exp_t q[$];

  logic [7:0] m_pc, m_fpc;
  logic [31:0] m_fin;
  logic m_fv, m_halt;
  logic [15:0] m_fc, m_bc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .alu_zero(alu_zero),
    .pc_branch(pc_branch), .jmp(jmp), .pc_jmp(pc_jmp), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .fd_pc(fd_pc), .fd_instr(fd_instr), .fd_valid(fd_valid),
    .halted(halted), .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  assign imem_instr = rom[imem_addr];
  always #5 clk = ~clk;

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_fpc = 0; m_fin = 0; m_fv = 0; m_halt = 0; m_fc = 0; m_bc = 0;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; branch = 0; alu_zero = 0; jmp = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    chk("rst_addr", imem_addr, 0);
    chk("rst_fd_pc", fd_pc, 0);
    chk("rst_fd_instr", fd_instr, 0);
    chk("rst_fd_valid", fd_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fetch_count", fetch_count, 0);
    chk("rst_bubble_count", bubble_count, 0);
  endtask

  task automatic cyc(input logic s, input logic b, input logic z, input logic [7:0] pb,
                     input logic j, input logic [7:0] pj);
    exp_t e, g;
    logic tk;
    tk = b & z;
    stall = s; branch = b; alu_zero = z; pc_branch = pb; jmp = j; pc_jmp = pj;
    if (tk || j) begin
      m_pc = tk ? pb : pj; m_fpc = 0; m_fin = 0; m_fv = 0; m_bc = sat(m_bc); m_halt = 0;
    end else if (m_halt) begin
      if (m_fv) m_bc = sat(m_bc);
      m_fpc = 0; m_fin = 0; m_fv = 0;
    end else if (!s) begin
      m_fin = rom[m_pc]; m_fpc = m_pc + 8'd1; m_fv = 1; m_fc = sat(m_fc);
      if (m_fin[31:26] == 6'h3F) m_halt = 1;
      else m_pc = m_pc + 8'd1;
    end
    e.addr = m_pc; e.fpc = m_fpc; e.fin = m_fin; e.fv = m_fv; e.hl = m_halt;
    e.fc = m_fc; e.bc = m_bc;
    q.push_back(e);
    @(posedge clk); #1;
    stall = 0; branch = 0; alu_zero = 0; jmp = 0;
    g = q.pop_front();
    chk("imem_addr", imem_addr, g.addr);
    chk("fd_pc", fd_pc, g.fpc);
    chk("fd_instr", fd_instr, g.fin);
    chk("fd_valid", fd_valid, g.fv);
    chk("halted", halted, g.hl);
    chk("fetch_count", fetch_count, g.fc);
    chk("bubble_count", bubble_count, g.bc);
  endtask

  task automatic run();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [7:0] t);
    cyc(0, 0, 0, 0, 1, t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 + i;
    rom[7] = 32'hFC00_0000;
    do_reset();
    run(); run(); run();
    chk("tp1_fd_instr", fd_instr, 32'h2000_0002);
    chk("tp1_fd_pc", fd_pc, 3);
    chk("tp1_fetch_count", fetch_count, 3);
    run(); run();
    chk("tp2_addr_pre_stall", imem_addr, 5);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("tp2_addr_stalled", imem_addr, 5);
    chk("tp2_fetch_frozen", fetch_count, 5);
    run();
    chk("tp2_release_instr", fd_instr, 32'h2000_0005);
    chk("tp2_release_pc", fd_pc, 6);
    run(); run();
    chk("halt_word", fd_instr, 32'hFC00_0000);
    chk("halt_word_pc", fd_pc, 8);
    chk("halt_pc_hold", imem_addr, 7);
    cyc(1, 0, 0, 0, 0, 0);
    chk("halted_set", halted, 1);
    chk("halt_bubble", bubble_count, 1);
    run(); run();
    chk("halt_bubble_once", bubble_count, 1);
    chk("halt_pc_stuck", imem_addr, 7);
    jump(8'h20);
    chk("halt_exit", halted, 0);
    chk("halt_exit_pc", imem_addr, 8'h20);
    run();
    jump(8'd10);
    cyc(1, 1, 1, 8'h40, 1, 8'h80);
    chk("br_beats_jmp", imem_addr, 8'h40);
    chk("br_flush", fd_valid, 0);
    run();
    chk("br_target_instr", fd_instr, 32'h2000_0040);
    jump(8'd10);
    cyc(0, 1, 0, 8'h40, 0, 0);
    chk("br_not_taken", imem_addr, 8'd11);
    jump(8'hFF);
    run();
    chk("wrap_fd_pc", fd_pc, 0);
    chk("wrap_pc", imem_addr, 0);
    jump(8'd7);
    run(); run();
    chk("pre_rst_halted", halted, 1);
    stall = 1; jmp = 1; pc_jmp = 8'h55;
    do_reset();
    rom[7] = 32'h2000_0007;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    chk("fetch_saturate", fetch_count, 16'hFFFF);
    chk("bubble_idle", bubble_count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
